inv_sub_bytes_serial: RTL and testbench
=======================================

// Module: inv_sub_bytes_serial
// PURPOSE
//  Decryption-side InvSubBytes engine: applies the AES inverse S-box to every byte of a 128-bit state.
//  Iterative, BPC bytes per cycle, valid/ready handshake on both sides.
//  Sits in the inverse round datapath between InvShiftRows and AddRoundKey.
//  Time-shares BPC inverse S-box instances instead of 16.
// PARAMETERS
//  BPC      4   bytes substituted per cycle; legal values 1,2,4,8,16
//  NSTEP    16/BPC (localparam)   cycles per block
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  flush      in   1    synchronous abort; drops any block in flight
//  in_valid   in   1    in_state is valid
//  in_ready   out  1    engine can accept a block this cycle
//  in_state   in   128  ciphertext-side state; byte k = in_state[8k+:8]
//  out_valid  out  1    out_state holds a finished block
//  out_ready  in   1    consumer accepts out_state this cycle
//  out_state  out  128  byte k = InvSbox(in_state byte k)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, count=0, out_valid=0, out_state=0, working register=0.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready); combinational, not gated by in_valid.
//  - FSM: IDLE --accept--> BUSY; BUSY --count==NSTEP-1--> DONE; DONE --out_ready & !accept--> IDLE;
//    DONE --out_ready & accept--> BUSY (back-to-back, no bubble).
//  - Accept = in_valid & in_ready: in_state latched into working register, count<=0.
//  - BUSY cycle c (0..NSTEP-1): bytes [c*BPC .. c*BPC+BPC-1] looked up and written into out_state
//    bytes of the same index; count increments; at c==NSTEP-1 out_valid<=1 next edge.
//  - Latency: accept at edge t -> out_valid high after edge t+NSTEP; BPC=16 gives 1-cycle BUSY.
//  - out_state/out_valid held stable while out_valid & !out_ready; out_state bytes not yet
//    written in current block are don't-care (not observable: out_valid=0).
//  - out_valid drops on the edge where out_ready=1 unless NSTEP==1 and a new block was accepted
//    then (still drops; new result appears NSTEP cycles later).
//  - Lookup: index = full byte value (high nibble*16 + low nibble); pure combinational table.
//  - flush: highest priority over accept/out_ready; next edge state=IDLE, out_valid=0, count=0;
//    in_ready is 0 during the flush cycle; out_state contents unchanged.
//  - rst_n asserted mid-block: everything returns to reset values immediately, no output.
//  - count width = max(1,$clog2(NSTEP)); no wrap beyond NSTEP-1 (FSM leaves BUSY first).
//  - in_state changes while BUSY are ignored (input is latched).
// STRUCTURE
//  - Shared AES package: INV_SBOX constant table (256x8) and the state_t 128-bit typedef,
//    shared with the forward SubBytes and key-expansion blocks.
//  - Sub-module inv_sbox: 8-bit in -> 8-bit out combinational lookup; BPC instances
//    generated, each fed by a BPC-wide byte mux driven by count.
//  - FSM, counter and registers in this module.
// TESTING
//  1 reset: rst_n=0 -> out_valid=0, out_state=0, in_ready=0 during reset, in_ready=1 after release.
//  2 single block: in_state=128'h6363..63 -> out_state=128'h0, out_valid at exactly
//    accept+NSTEP; bytes 0x7C->0x01, 0x00->0x52, 0x16->0xFF, 0xED->0x53 in assorted lanes.
//  3 exhaustive: 16 blocks covering all 256 byte values; each out byte = InvSbox; forward
//    SubBytes of out_state reproduces in_state.
//  4 backpressure: out_ready=0 for 10 cycles -> out_state/out_valid stable, in_ready=0;
//    then out_ready=1 with in_valid=1 -> next block accepted same cycle, zero bubble.
//  5 flush mid-BUSY (count=1) -> IDLE next cycle, out_valid never asserts for that block;
//    following block correct.
//  6 async reset mid-BUSY and sweep BPC=1,2,4,8,16 -> latency 16,8,4,2,1, results identical.

Source files
------------

// File: rtl/inv_sub_bytes_serial_pkg.sv
// Shared AES definitions used by the SubBytes, InvSubBytes and key-expansion
// blocks: the 128-bit state type, the engine FSM states and the inverse S-box
// table (index = full byte value, high nibble selects the row).
package inv_sub_bytes_serial_pkg;

  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sub_bytes_serial_inv_sbox.sv
// inv_sbox: purely combinational AES inverse S-box lookup.
//   data    in  8  byte to substitute
//   result  out 8  InvSbox(data)
module inv_sbox
  import inv_sub_bytes_serial_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] result
);

  assign result = INV_SBOX[data];

endmodule

// File: rtl/inv_sub_bytes_serial.sv
// inv_sub_bytes_serial: iterative InvSubBytes engine. A 128-bit state is
// latched on accept and substituted BPC bytes per cycle through BPC shared
// inverse S-box instances; the finished block is held until consumed.
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   flush      in   1    synchronous abort of any block in flight
//   in_valid   in   1    in_state is valid
//   in_ready   out  1    a block can be accepted this cycle
//   in_state   in   128  input state, byte k = in_state[8k+:8]
//   out_valid  out  1    out_state holds a finished block
//   out_ready  in   1    consumer takes out_state this cycle
//   out_state  out  128  byte k = InvSbox(input byte k)
module inv_sub_bytes_serial
  import inv_sub_bytes_serial_pkg::*;
#(
  parameter int unsigned BPC = 4
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int unsigned NSTEP = 16 / BPC;
  localparam int unsigned CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  fsm_state_e    state, state_n;
  logic [CW-1:0] count, count_n;
  state_t        work;
  state_t        out_next;
  logic          out_valid_n;
  logic          accept;
  logic [7:0]    lane_in  [BPC];
  logic [7:0]    lane_out [BPC];

  // rst_n is folded in so nothing looks acceptable while reset is held.
  assign in_ready = rst_n & ~flush &
                    ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  // Lane j of step c handles byte c*BPC + j.
  always_comb begin
    for (int unsigned j = 0; j < BPC; j++) begin
      lane_in[j] = work[8 * (32'(count) * BPC + j) +: 8];
    end
  end

  for (genvar g = 0; g < BPC; g++) begin : g_lane
    inv_sbox u_inv_sbox (
      .data   (lane_in[g]),
      .result (lane_out[g])
    );
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    out_valid_n = out_valid;
    out_next    = out_state;
    if (flush) begin
      state_n     = IDLE;
      count_n     = '0;
      out_valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_n = BUSY;
            count_n = '0;
          end
        end
        BUSY: begin
          for (int unsigned j = 0; j < BPC; j++) begin
            out_next[8 * (32'(count) * BPC + j) +: 8] = lane_out[j];
          end
          if (count == LAST) begin
            state_n     = DONE;
            count_n     = '0;
            out_valid_n = 1'b1;
          end else begin
            count_n = count + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_n = 1'b0;
            if (accept) begin
              state_n = BUSY;
              count_n = '0;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      out_valid <= 1'b0;
      out_state <= '0;
      work      <= '0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      out_valid <= out_valid_n;
      out_state <= out_next;
      if (accept) begin
        work <= in_state;
      end
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_serial.sv
// Self-checking bench for inv_sub_bytes_serial. The reference S-box tables
// are derived from GF(2^8) arithmetic (multiplicative inverse + affine map).
module tb_inv_sub_bytes_serial;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_state, out_state;

  logic         sw_in_valid, sw_out_ready;
  logic [127:0] sw_in_state;
  logic         sw_in_ready  [5];
  logic         sw_out_valid [5];
  logic [127:0] sw_out_state [5];

  int checks = 0;
  int errors = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  inv_sub_bytes_serial #(.BPC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  for (genvar g = 0; g < 5; g++) begin : g_sweep
    inv_sub_bytes_serial #(.BPC(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (1'b0),
      .in_valid  (sw_in_valid),
      .in_ready  (sw_in_ready[g]),
      .in_state  (sw_in_state),
      .out_valid (sw_out_valid[g]),
      .out_ready (sw_out_ready),
      .out_state (sw_out_state[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] iv, s;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_inv(input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] model_fwd(input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = fwd_tab[d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the accept edge until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    #1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic send(input logic [127:0] d, output int lat);
    int n;
    in_state = d;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check("accept_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    in_state = rand128();
    wait_out(lat);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check("drain_valid_drop", 128'(out_valid), 128'd0);
  endtask

  task automatic run_block(input string tag, input logic [127:0] d);
    int lat;
    send(d, lat);
    check({tag, "_lat"}, 128'(lat), 128'd4);
    check({tag, "_data"}, out_state, model_inv(d));
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int lat;
    logic [127:0] d, held;
    logic [7:0]   perm [256];
    logic [7:0]   tmp;
    int           r;
    int           sw_lat [5];
    bit           all_done;

    build_tables();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
    sw_in_valid = 1'b0; sw_out_ready = 1'b0; sw_in_state = '0;

    // 1: reset
    tick(); tick();
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_state", out_state, 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'd1);
    tick();

    // 2: single blocks
    send({16{8'h63}}, lat);
    check("b63_lat", 128'(lat), 128'd4);
    check("b63_data", out_state, 128'd0);
    drain();
    d = rand128();
    d[7:0] = 8'h7c; d[47:40] = 8'h00; d[87:80] = 8'h16; d[127:120] = 8'hed;
    send(d, lat);
    check("lanes_lat", 128'(lat), 128'd4);
    check("lane0_7c", 128'(out_state[7:0]), 128'h01);
    check("lane5_00", 128'(out_state[47:40]), 128'h52);
    check("lane10_16", 128'(out_state[87:80]), 128'hff);
    check("lane15_ed", 128'(out_state[127:120]), 128'h53);
    check("lanes_data", out_state, model_inv(d));
    drain();

    // 3: all 256 byte values in a random order
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      r = int'($urandom_range(i, 0));
      tmp = perm[i]; perm[i] = perm[r]; perm[r] = tmp;
    end
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) d[8*k +: 8] = perm[16*b + k];
      send(d, lat);
      check("exh_lat", 128'(lat), 128'd4);
      check("exh_data", out_state, model_inv(d));
      check("exh_roundtrip", model_fwd(out_state), d);
      drain();
    end

    // 4: backpressure then back-to-back accept
    d = rand128();
    send(d, lat);
    check("bp_a_data", out_state, model_inv(d));
    held = out_state;
    d = rand128();
    in_state = d;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_hold_state", out_state, held);
      check("bp_hold_valid", 128'(out_valid), 128'd1);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_state = rand128();
    check("b2b_valid_drop", 128'(out_valid), 128'd0);
    wait_out(lat);
    check("b2b_lat", 128'(lat), 128'd4);
    check("b2b_data", out_state, model_inv(d));
    drain();

    // 5: flush at count=1
    in_state = rand128();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    in_valid = 1'b1;
    in_state = rand128();
    #1;
    check("flush_in_ready", 128'(in_ready), 128'd0);
    held = out_state;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_state_kept", out_state, held);
    for (int i = 0; i < 8; i++) begin
      check("flush_no_valid", 128'(out_valid), 128'd0);
      tick();
    end
    check("flush_idle_ready", 128'(in_ready), 128'd1);
    run_block("post_flush", rand128());

    // 6a: asynchronous reset mid-block
    in_state = rand128();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'd0);
    check("arst_out_state", out_state, 128'd0);
    check("arst_in_ready", 128'(in_ready), 128'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("arst_rel_ready", 128'(in_ready), 128'd1);
    for (int i = 0; i < 6; i++) begin
      check("arst_no_valid", 128'(out_valid), 128'd0);
      tick();
    end
    run_block("post_arst", rand128());

    // 6b: BPC sweep
    for (int t = 0; t < 4; t++) begin
      d = (t == 0) ? {16{8'h63}} : rand128();
      sw_in_state = d;
      sw_in_valid = 1'b1;
      #1;
      for (int g = 0; g < 5; g++) check("sw_in_ready", 128'(sw_in_ready[g]), 128'd1);
      tick();
      sw_in_valid = 1'b0;
      sw_in_state = rand128();
      for (int g = 0; g < 5; g++) sw_lat[g] = -1;
      for (int n = 0; n < 40; n++) begin
        all_done = 1'b1;
        for (int g = 0; g < 5; g++) begin
          if (sw_out_valid[g] && sw_lat[g] < 0) sw_lat[g] = n;
          if (sw_lat[g] < 0) all_done = 1'b0;
        end
        if (all_done) break;
        tick();
      end
      for (int g = 0; g < 5; g++) begin
        check("sw_lat", 128'(sw_lat[g]), 128'(16 >> g));
        check("sw_data", sw_out_state[g], model_inv(d));
      end
      sw_out_ready = 1'b1;
      tick();
      sw_out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
